jk_sync_counter: RTL and testbench

//  - Synchronous modulo-N up/down counter built from JK flip-flop cells.
//  - Each bit is one JK cell. A shared next-state block turns the wanted next count into J/K pairs

---
 rtl/jk_cnt_pkg.sv | 24 ++
 rtl/jk_cell.sv | 32 +++
 rtl/jk_sync_counter.sv | 106 ++++++++++
 tb/tb_jk_sync_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/jk_cnt_pkg.sv
// Shared types and the JK excitation helper for the jk_sync_counter slice.
package jk_cnt_pkg;

    typedef struct packed {
        logic j;
        logic k;
    } jk_pair_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_t;

    // Drives only set or clear, never toggle, so J and K are never high together.
    function automatic jk_pair_t jk_excite(input logic q, input logic nxt);
        jk_pair_t p;
        p.j = ~q & nxt;
        p.k = q & ~nxt;
        return p;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset and per-instance reset value.
module jk_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_q_bar
);

    logic r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RESET_BIT;
        end else begin
            case ({i_j, i_k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign o_q     = r_q;
    assign o_q_bar = ~r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-N up/down counter built from JK cells; define JK_CNT_SATURATE_EN to
// saturate at the range limits instead of wrapping (wrap output then tied low).
module jk_sync_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    cnt_op_t          w_op;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_nxt;

    assign w_at_max  = (w_q == MAX_VAL);
    assign w_at_zero = (w_q == '0);

    always_comb begin
        w_op = OP_HOLD;
        if (load)    w_op = OP_LOAD;
        else if (en) w_op = up ? OP_UP : OP_DOWN;
    end

    // NOTE: w_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_nxt      = w_q;
        w_wrap_nxt = 1'b0;
        case (w_op)
            OP_LOAD: w_nxt = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;
            OP_UP: begin
`ifdef JK_CNT_SATURATE_EN
                w_nxt = w_at_max ? MAX_VAL : w_q + 1'b1;
`else
                w_nxt      = w_at_max ? '0 : w_q + 1'b1;
                w_wrap_nxt = w_at_max;
`endif
            end
            OP_DOWN: begin
`ifdef JK_CNT_SATURATE_EN
                w_nxt = w_at_zero ? '0 : w_q - 1'b1;
`else
                w_nxt      = w_at_zero ? MAX_VAL : w_q - 1'b1;
                w_wrap_nxt = w_at_zero;
`endif
            end
            default: w_nxt = w_q;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_pair_t w_pair;
        assign w_pair = jk_excite(w_q[g], w_nxt[g]);
        assign w_j[g] = w_pair.j;
        assign w_k[g] = w_pair.k;

        jk_cell #(.RESET_BIT(RST_V[g])) u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_j     (w_j[g]),
            .i_k     (w_k[g]),
            .o_q     (w_q[g]),
            .o_q_bar (w_q_bar[g])
        );
    end

    assign count     = w_q;
    assign count_bar = w_q_bar;
    assign tc        = en & (up ? w_at_max : w_at_zero);

`ifdef JK_CNT_SATURATE_EN
    logic w_unused_wrap;
    assign w_unused_wrap = w_wrap_nxt;
    assign wrap          = 1'b0;
`else
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (!rst) r_wrap <= 1'b0;
        else      r_wrap <= w_wrap_nxt;
    end

    assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// Self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10); honours JK_CNT_SATURATE_EN.
module tb_jk_sync_counter;

    localparam int W = 4;
    localparam int M = 10;
    localparam int RV = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic [W-1:0] count_bar;
    logic         tc;
    logic         wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_count = 0;
    bit m_wrap  = 1'b0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .count_bar (count_bar),
        .tc        (tc),
        .wrap      (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the count value.
    always @(posedge clk) begin
        if (!rst) begin
            m_count = RV;
            m_wrap  = 1'b0;
            m_valid = 1'b1;
        end else if (load) begin
            m_count = (int'(load_val) >= M) ? M - 1 : int'(load_val);
            m_wrap  = 1'b0;
        end else if (en) begin
`ifdef JK_CNT_SATURATE_EN
            m_wrap  = 1'b0;
            m_count = up ? ((m_count + 1 > M - 1) ? M - 1 : m_count + 1)
                         : ((m_count - 1 < 0) ? 0 : m_count - 1);
`else
            m_wrap  = up ? (m_count + 1 == M) : (m_count == 0);
            m_count = up ? (m_count + 1) % M : (m_count + M - 1) % M;
`endif
        end else begin
            m_wrap = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("count", 32'(count), 32'(m_count));
            check("count_bar", 32'(count_bar), 32'(~m_count) & 32'hF);
            check("tc", 32'(tc), 32'(en && (up ? m_count == M - 1 : m_count == 0)));
            check("wrap", 32'(wrap), 32'(m_wrap));
            check("jk_excl", 32'(dut.w_j & dut.w_k), 32'd0);
            if (rst && !load && !en)
                check("jk_hold", 32'(dut.w_j | dut.w_k), 32'd0);
        end
    end

    initial begin
        int exp_up[3];
        int exp_dn[3];
`ifdef JK_CNT_SATURATE_EN
        exp_up = '{9, 9, 9};
        exp_dn = '{0, 0, 0};
`else
        exp_up = '{9, 0, 1};
        exp_dn = '{0, 9, 8};
`endif

        // Reset, then count up through the wrap
        tick(); tick();
        check("lit_reset", 32'(count), 32'd0);
        rst = 1'b1; en = 1'b1; up = 1'b1;
        repeat (9) tick();
        check("lit_up9", 32'(count), 32'd9);
        check("lit_tc9", 32'(tc), 32'd1);
`ifndef JK_CNT_SATURATE_EN
        tick();
        check("lit_wrap0", 32'(count), 32'd0);
        check("lit_wrap_pulse", 32'(wrap), 32'd1);
        tick();
        check("lit_wrap_gone", 32'(wrap), 32'd0);

        // Count down through the wrap
        up = 1'b0;
        tick();
        check("lit_dn0", 32'(count), 32'd0);
        check("lit_tc0", 32'(tc), 32'd1);
        tick();
        check("lit_dn9", 32'(count), 32'd9);
        check("lit_dn_wrap", 32'(wrap), 32'd1);
        tick(); tick();
        check("lit_dn7", 32'(count), 32'd7);
`endif

        // Load and clamp
        load = 1'b1; load_val = 4'd6;
        tick();
        check("lit_load6", 32'(count), 32'd6);
        load_val = 4'd13;
        tick();
        check("lit_clamp", 32'(count), 32'd9);
        up = 1'b1; load_val = 4'd0;
        tick();
        check("lit_load_wins", 32'(count), 32'd0);
        check("lit_load_nowrap", 32'(wrap), 32'd0);
        load = 1'b0;
        repeat (5) tick();
        check("lit_up5", 32'(count), 32'd5);

        // Reset overrides load/en, then hold
        rst = 1'b0; load = 1'b1; load_val = 4'd3;
        tick();
        check("lit_midrst", 32'(count), 32'd0);
        check("lit_midrst_wrap", 32'(wrap), 32'd0);
        rst = 1'b1; en = 1'b0; load = 1'b0;
        repeat (4) tick();
        check("lit_hold", 32'(count), 32'd0);

        // Limits: saturate or wrap depending on build
        load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_lim_up", 32'(count), 32'(exp_up[i]));
        end
        load = 1'b1; load_val = 4'd1;
        tick();
        load = 1'b0; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit_lim_dn", 32'(count), 32'(exp_dn[i]));
        end

        // Random traffic; the compare process checks every cycle
        for (int i = 0; i < 1000; i++) begin
            rst      = ($urandom_range(0, 49) != 0);
            load     = ($urandom_range(0, 7) == 0);
            en       = 1'($urandom_range(0, 1));
            up       = 1'($urandom_range(0, 1));
            load_val = 4'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
